// File: rtl/ram_bist_if.sv
// ----------------------------------------------------------------------------
// ram_bist_if
//   Single-port RAM access bundle shared by the BIST initiator and the RAM.
//
//   mem_we     initiator -> RAM   write enable
//   mem_addr   initiator -> RAM   address
//   mem_wdata  initiator -> RAM   write data
//   mem_rdata  RAM -> initiator   read data, valid the cycle after a read
//                                 address is presented with mem_we = 0
//
//   master : the BIST controller side
//   slave  : the RAM side
// ----------------------------------------------------------------------------
interface ram_bist_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 10
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/ram_bist.sv
// ----------------------------------------------------------------------------
// ram_bist
//   Built-in self-test controller for a single-port RAM. A start pulse in IDLE
//   latches the seed, writes exp(a) = a ^ seed to every address 0..LAST_ADDR,
//   reads every address back and compares it with exp(a) one cycle later.
//   Reports pass/fail, a saturating mismatch count and the first failing
//   address.
//
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      one-cycle run request, honoured only in IDLE
//   seed       pattern seed, latched when start is honoured
//   mem        RAM port (master side of ram_bist_if)
//   busy       high from the cycle after start through the DONE cycle
//   done       one-cycle pulse at the end of a run
//   pass       run ended with zero mismatches; held until next start/reset
//   err_count  mismatch count, saturates at all-ones
//   fail_addr  address of the first mismatch, 0 if none
// ----------------------------------------------------------------------------
module ram_bist #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 10,
    parameter int LAST_ADDR = 2**ADDR_W - 1,
    parameter int ERR_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    ram_bist_if.master        mem,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] fail_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(LAST_ADDR);
    localparam logic [ERR_W-1:0]  ERR_MAX = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic              cmp_valid_q, cmp_valid_d;
    logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [ADDR_W-1:0] fail_q, fail_d;
    logic              pass_q, pass_d;

    logic [DATA_W-1:0] cmp_exp;
    logic              mismatch;

    // Address is zero-extended or truncated to the data width before the XOR.
    assign cmp_exp  = DATA_W'(cmp_addr_q) ^ seed_q;
    assign mismatch = cmp_valid_q && (mem.mem_rdata != cmp_exp);

    // ------------------------------------------------------------------------
    // Next-state and RAM-port logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // through the case statement can leave one unassigned (no latches).
        state_d       = state_q;
        addr_d        = addr_q;
        seed_d        = seed_q;
        cmp_valid_d   = 1'b0;
        cmp_addr_d    = cmp_addr_q;
        err_d         = err_q;
        fail_d        = fail_q;
        pass_d        = pass_q;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;

        // Compare stage: runs whenever a read was issued last cycle. The first
        // mismatch of a run is the one seen while the count is still zero;
        // the count never returns to zero inside a run, so fail_addr is
        // never overwritten even after saturation.
        if (mismatch) begin
            if (err_q != ERR_MAX) begin
                err_d = err_q + ERR_W'(1);
            end
            if (err_q == '0) begin
                fail_d = cmp_addr_q;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WRITE;
                    addr_d  = '0;
                    seed_d  = seed;
                    err_d   = '0;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            S_WRITE: begin
                mem.mem_we    = 1'b1;
                mem.mem_addr  = addr_q;
                mem.mem_wdata = DATA_W'(addr_q) ^ seed_q;
                if (addr_q == LAST) begin
                    state_d = S_READ;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_READ: begin
                mem.mem_addr = addr_q;
                cmp_valid_d  = 1'b1;
                cmp_addr_d   = addr_q;
                if (addr_q == LAST) begin
                    // addr stays at LAST so DRAIN keeps presenting it.
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                mem.mem_addr = addr_q;
                state_d      = S_DONE;
                // Includes the final compare being resolved this cycle.
                pass_d       = (err_d == '0);
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the reset branch clears every register, so all outputs and the
        // RAM port (decoded from state_q) drop to zero as soon as rst_n falls.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            seed_q      <= '0;
            cmp_valid_q <= 1'b0;
            cmp_addr_q  <= '0;
            err_q       <= '0;
            fail_q      <= '0;
            pass_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q     <= state_d;
            addr_q      <= addr_d;
            seed_q      <= seed_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_addr_q  <= cmp_addr_d;
            err_q       <= err_d;
            fail_q      <= fail_d;
            pass_q      <= pass_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_addr = fail_q;

endmodule

// File: tb/tb_ram_bist.sv
// ----------------------------------------------------------------------------
// tb_ram_bist
//   Two controllers: a full-size one (LAST_ADDR = 1023) on a RAM model with
//   injectable read faults, and a 4-location one for an exact cycle trace.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_ram_bist;

    localparam int AW   = 10;
    localparam int DW   = 10;
    localparam int EW   = 8;
    localparam int NB   = 1024;
    localparam int NS   = 4;
    localparam int TMO  = 3000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start_b = 1'b0, start_s = 1'b0;
    logic [DW-1:0] seed_b = '0, seed_s = '0;
    logic          busy_b, done_b, pass_b, busy_s, done_s, pass_s;
    logic [EW-1:0] err_b, err_s;
    logic [AW-1:0] fail_b, fail_s;

    ram_bist_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();
    ram_bist_if #(.ADDR_W(AW), .DATA_W(DW)) bus_s ();

    ram_bist #(.ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(NB-1), .ERR_W(EW)) u_big (
        .clk(clk), .rst_n(rst_n), .start(start_b), .seed(seed_b), .mem(bus_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .fail_addr(fail_b)
    );

    ram_bist #(.ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(NS-1), .ERR_W(EW)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start_s), .seed(seed_s), .mem(bus_s),
        .busy(busy_s), .done(done_s), .pass(pass_s),
        .err_count(err_s), .fail_addr(fail_s)
    );

    // RAM models: synchronous write, registered read (1-cycle latency).
    logic [DW-1:0] ram_b  [NB];
    logic [DW-1:0] flip_b [NB];
    logic          stuck_b = 1'b0;
    logic [DW-1:0] ram_s  [NB];

    always @(posedge clk) begin
        if (bus_b.mem_we) ram_b[bus_b.mem_addr] <= bus_b.mem_wdata;
        else bus_b.mem_rdata <= stuck_b ? '0 : (ram_b[bus_b.mem_addr] ^ flip_b[bus_b.mem_addr]);
        if (bus_s.mem_we) ram_s[bus_s.mem_addr] <= bus_s.mem_wdata;
        else bus_s.mem_rdata <= ram_s[bus_s.mem_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: what a correct BIST reports, given the seed and the fault
    // configuration of the RAM model, assuming every write lands intact.
    function automatic void model(input logic [DW-1:0] s, output int e, output int f);
        e = 0;
        f = 0;
        for (int a = 0; a < NB; a++) begin
            logic [DW-1:0] want, got;
            want = DW'(a) ^ s;
            got  = stuck_b ? '0 : (want ^ flip_b[a]);
            if (got != want) begin
                if (e == 0) f = a;
                if (e < 255) e++;
            end
        end
    endfunction

    task automatic clear_faults();
        for (int a = 0; a < NB; a++) flip_b[a] = '0;
        stuck_b = 1'b0;
    endtask

    // One full run on the big controller. Cycle k is the k-th cycle after the
    // edge that honours start; done must appear at k = 2*NB + 2.
    task automatic run_big(input string tag, input logic [DW-1:0] s, input bit poke,
                           input int exp_err, input int exp_fail, input bit exp_pass);
        int k;
        int bad;
        @(negedge clk);
        seed_b  = s;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        k = 1;
        check({tag, "_first_we"},    32'(bus_b.mem_we),    32'd1);
        check({tag, "_first_addr"},  32'(bus_b.mem_addr),  32'd0);
        check({tag, "_first_wdata"}, 32'(bus_b.mem_wdata), 32'(s));
        check({tag, "_busy"},        32'(busy_b),          32'd1);
        while (!done_b && k < TMO) begin
            start_b = poke && (k == 20 || k == NB + 5);
            @(negedge clk);
            k++;
        end
        start_b = 1'b0;
        check({tag, "_done_cycle"}, 32'(k),      32'(2 * NB + 2));
        check({tag, "_pass"},       32'(pass_b), 32'(exp_pass));
        check({tag, "_err"},        32'(err_b),  32'(exp_err));
        check({tag, "_fail_addr"},  32'(fail_b), 32'(exp_fail));
        bad = 0;
        for (int a = 0; a < NB; a++) if (ram_b[a] !== (DW'(a) ^ s)) bad++;
        check({tag, "_ram_image"}, 32'(bad), 32'd0);
        @(negedge clk);
        check({tag, "_idle_busy"}, 32'({busy_b, done_b}), 32'd0);
        check({tag, "_pass_held"}, 32'(pass_b), 32'(exp_pass));
    endtask

    // Exact trace of the 4-location controller, seed 0x3FF.
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            chk_addr;
        logic          busy;
        logic          done;
    } trace_t;

    // Directed scenarios for the big controller.
    typedef struct {
        string         name;
        logic [DW-1:0] seed;
        bit            stuck;
        int            flip_addr;
        int            exp_err;
        int            exp_fail;
        bit            exp_pass;
    } scen_t;

    initial begin
        trace_t trace [11];
        scen_t  scen  [3];
        int     k, e, f, n;

        for (int i = 0; i < 4; i++) trace[i] = '{1'b1, AW'(i), DW'(10'h3FF ^ i), 1'b1, 1'b1, 1'b0};
        for (int i = 4; i < 8; i++) trace[i] = '{1'b0, AW'(i - 4), '0, 1'b1, 1'b1, 1'b0};
        trace[8]  = '{1'b0, AW'(3), '0, 1'b1, 1'b1, 1'b0};
        trace[9]  = '{1'b0, '0,     '0, 1'b0, 1'b1, 1'b1};
        trace[10] = '{1'b0, '0,     '0, 1'b1, 1'b0, 1'b0};

        scen[0] = '{"clean",  10'h155, 1'b0, -1,   0,   0,     1'b1};
        scen[1] = '{"flip3a", 10'h155, 1'b0, 'h3A, 1,   'h3A,  1'b0};
        scen[2] = '{"stuck0", 10'h000, 1'b1, -1,   255, 1,     1'b0};

        clear_faults();

        // Reset state.
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mem", 32'({bus_b.mem_we, bus_b.mem_addr, bus_b.mem_wdata}), 32'd0);
        check("rst_status", 32'({busy_b, done_b, pass_b, err_b, fail_b}), 32'd0);

        // Exact cycle trace on the small controller.
        seed_s  = 10'h3FF;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("trace%0d_we", i + 1),   32'(bus_s.mem_we), 32'(trace[i].we));
            check($sformatf("trace%0d_ctl", i + 1),  32'({busy_s, done_s}), 32'({trace[i].busy, trace[i].done}));
            if (trace[i].chk_addr) check($sformatf("trace%0d_addr", i + 1), 32'(bus_s.mem_addr), 32'(trace[i].addr));
            if (trace[i].we) check($sformatf("trace%0d_wdata", i + 1), 32'(bus_s.mem_wdata), 32'(trace[i].wdata));
            if (trace[i].done) check("small_pass", 32'({pass_s, err_s}), 32'h100);
        end

        // Directed scenarios.
        foreach (scen[j]) begin
            clear_faults();
            stuck_b = scen[j].stuck;
            if (scen[j].flip_addr >= 0) flip_b[scen[j].flip_addr] = 10'h001;
            run_big(scen[j].name, scen[j].seed, 1'b0, scen[j].exp_err, scen[j].exp_fail, scen[j].exp_pass);
            if (j == 0) begin
                check("ram5",    32'(ram_b[5]),    32'h150);
                check("ram1023", 32'(ram_b[1023]), 32'h2AA);
            end
        end

        // start pulsed during WRITE and READ is ignored.
        clear_faults();
        run_big("poke", 10'h2C3, 1'b1, 0, 0, 1'b1);

        // Asynchronous reset in the middle of WRITE.
        @(negedge clk);
        seed_b  = 10'h0F0;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        k = 1;
        while (!(bus_b.mem_we && bus_b.mem_addr == 10'h100) && k < TMO) begin
            @(negedge clk);
            k++;
        end
        check("reach_0x100", 32'(k), 32'd257);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mem", 32'({bus_b.mem_we, bus_b.mem_addr, bus_b.mem_wdata}), 32'd0);
        check("arst_status", 32'({busy_b, done_b, pass_b, err_b, fail_b}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_big("after_rst", 10'h0F0, 1'b0, 0, 0, 1'b1);

        // Randomized runs against the reference model.
        for (int r = 0; r < 4; r++) begin
            logic [DW-1:0] s;
            int mode;
            clear_faults();
            s    = DW'($urandom);
            mode = $urandom_range(0, 2);
            if (mode == 1) begin
                n = $urandom_range(1, 3);
                for (int j = 0; j < n; j++) flip_b[$urandom_range(0, NB - 1)] = DW'($urandom_range(1, 1023));
            end else if (mode == 2) begin
                stuck_b = 1'b1;
            end
            model(s, e, f);
            run_big($sformatf("rand%0d", r), s, 1'b0, e, f, e == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
